// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables and bubbles for
// load-use, EX redirects, LSU back-pressure and multi-cycle MUL/DIV.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_ren,
  input  logic       id_rs2_ren,
  input  logic [4:0] ex_rd,
  input  logic       ex_wen,
  input  logic       ex_load,
  input  logic       ex_mdu,
  input  logic       ex_redirect,
  input  logic       mem_busy,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       mdu_start,
  output logic       mdu_done,
  output logic       mdu_busy
);

  typedef enum logic [1:0] {
    S_RUN,
    S_MDU,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LAT_M1 =
    CNT_W'(MDU_LAT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_zero;
  logic             w_rs1_hit;
  logic             w_rs2_hit;
  logic             w_lu_hit;
  logic             w_mdu_acc;

  assign w_cnt_zero = (r_cnt == '0);

  assign w_rs1_hit = id_rs1_ren
                   & (id_rs1 == ex_rd);
  assign w_rs2_hit = id_rs2_ren
                   & (id_rs2 == ex_rd);
  assign w_lu_hit  = ex_load & ex_wen
                   & (ex_rd != 5'd0)
                   & (w_rs1_hit | w_rs2_hit);

  // MDU is accepted only when no higher-priority RUN case applies
  assign w_mdu_acc = ~mem_busy
                   & ~ex_redirect
                   & ex_mdu;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_RUN: begin
        if (w_mdu_acc) begin
          w_state_nxt = S_MDU;
          w_cnt_nxt   = LAT_M1;
        end
      end
      S_MDU: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (mem_busy) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_HOLD: begin
        if (!mem_busy) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mdu_start   = 1'b0;
    mdu_done    = 1'b0;
    mdu_busy    = 1'b0;
    if (rst) begin
      mdu_busy = (r_state != S_RUN);
      unique case (r_state)
        S_RUN: begin
          if (mem_busy) begin
            pc_en = 1'b0;
          end else if (ex_redirect) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_mdu) begin
            mdu_start   = 1'b1;
            exmem_en    = 1'b1;
            exmem_flush = 1'b1;
          end else if (w_lu_hit) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
          end
        end
        S_MDU: begin
          if (!w_cnt_zero) begin
            exmem_en    = ~mem_busy;
            exmem_flush = ~mem_busy;
          end else begin
            mdu_done = 1'b1;
            pc_en    = ~mem_busy;
            ifid_en  = ~mem_busy;
            idex_en  = ~mem_busy;
            exmem_en = ~mem_busy;
          end
        end
        S_HOLD: begin
          mdu_done = 1'b1;
          pc_en    = ~mem_busy;
          ifid_en  = ~mem_busy;
          idex_en  = ~mem_busy;
          exmem_en = ~mem_busy;
        end
        default: mdu_busy = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with MDU_LAT=4.
// Output vector: {pc,ifid,idex,exmem en, if/id/ex flush, start,done,busy}.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_ren;
  logic       id_rs2_ren;
  logic [4:0] ex_rd;
  logic       ex_wen;
  logic       ex_load;
  logic       ex_mdu;
  logic       ex_redirect;
  logic       mem_busy;
  logic       pc_en;
  logic       ifid_en;
  logic       idex_en;
  logic       exmem_en;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exmem_flush;
  logic       mdu_start;
  logic       mdu_done;
  logic       mdu_busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rst;
    logic       mdu;
    logic       redir;
    logic       mbusy;
    logic       load;
    logic       wen;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       r1en;
    logic [4:0] rs2;
    logic       r2en;
  } stim_t;

  localparam logic [9:0] ZERO   = 10'b0000_000_000;
  localparam logic [9:0] RUNV   = 10'b1111_000_000;
  localparam logic [9:0] REDIR  = 10'b1111_110_000;
  localparam logic [9:0] LU     = 10'b0011_010_000;
  localparam logic [9:0] MSTART = 10'b0001_001_100;
  localparam logic [9:0] MWAIT  = 10'b0001_001_001;
  localparam logic [9:0] MWAITB = 10'b0000_000_001;
  localparam logic [9:0] MDONE  = 10'b1111_000_011;
  localparam logic [9:0] MDONEB = 10'b0000_000_011;

  logic [9:0] sb[$];

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_ren(id_rs1_ren),
    .id_rs2_ren(id_rs2_ren),
    .ex_rd(ex_rd), .ex_wen(ex_wen),
    .ex_load(ex_load), .ex_mdu(ex_mdu),
    .ex_redirect(ex_redirect),
    .mem_busy(mem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush),
    .idex_flush(idex_flush),
    .exmem_flush(exmem_flush),
    .mdu_start(mdu_start),
    .mdu_done(mdu_done),
    .mdu_busy(mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(
    input logic rs, input logic md,
    input logic rdr, input logic mb);
    stim_t s;
    s = '0;
    s.rst = rs; s.mdu = md;
    s.redir = rdr; s.mbusy = mb;
    return s;
  endfunction

  function automatic stim_t mk_lu(
    input logic [4:0] rd,
    input logic [4:0] rs1, input logic r1en,
    input logic [4:0] rs2, input logic r2en);
    stim_t s;
    s = mk(1, 0, 0, 0);
    s.load = 1'b1; s.wen = 1'b1; s.rd = rd;
    s.rs1 = rs1; s.r1en = r1en;
    s.rs2 = rs2; s.r2en = r2en;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; ex_mdu = s.mdu;
    ex_redirect = s.redir; mem_busy = s.mbusy;
    ex_load = s.load; ex_wen = s.wen;
    ex_rd = s.rd;
    id_rs1 = s.rs1; id_rs1_ren = s.r1en;
    id_rs2 = s.rs2; id_rs2_ren = s.r2en;
  endtask

  function automatic logic [9:0] outs();
    return {pc_en, ifid_en, idex_en, exmem_en,
            ifid_flush, idex_flush, exmem_flush,
            mdu_start, mdu_done, mdu_busy};
  endfunction

  task automatic test_reset();
    stim_t st[$];
    logic [9:0] ex[$];
    logic [9:0] got, e;
    st.push_back(mk(0, 1, 1, 0)); ex.push_back(ZERO);
    st.push_back(mk(0, 0, 0, 1)); ex.push_back(ZERO);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(RUNV);
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = outs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset row %0d: got %b want %b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t st[$];
    logic [9:0] ex[$];
    logic [9:0] got, e;
    stim_t s;
    st.push_back(mk_lu(5, 0, 0, 5, 1)); ex.push_back(LU);
    st.push_back(mk(1, 0, 0, 0));       ex.push_back(RUNV);
    st.push_back(mk_lu(7, 7, 1, 3, 1)); ex.push_back(LU);
    st.push_back(mk_lu(0, 0, 1, 0, 1)); ex.push_back(RUNV);
    st.push_back(mk_lu(5, 0, 0, 5, 0)); ex.push_back(RUNV);
    s = mk_lu(5, 5, 1, 0, 0); s.wen = 1'b0;
    st.push_back(s);                    ex.push_back(RUNV);
    s = mk_lu(9, 9, 1, 0, 0); s.load = 1'b0;
    st.push_back(s);                    ex.push_back(RUNV);
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = outs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL load_use row %0d: got %b want %b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    stim_t st[$];
    logic [9:0] ex[$];
    logic [9:0] got, e;
    stim_t s;
    s = mk_lu(5, 0, 0, 5, 1); s.redir = 1'b1;
    st.push_back(s);               ex.push_back(REDIR);
    st.push_back(mk(1, 1, 1, 0));  ex.push_back(REDIR);
    st.push_back(mk(1, 0, 1, 1));  ex.push_back(ZERO);
    st.push_back(mk(1, 0, 1, 1));  ex.push_back(ZERO);
    st.push_back(mk(1, 0, 1, 0));  ex.push_back(REDIR);
    st.push_back(mk(1, 0, 0, 0));  ex.push_back(RUNV);
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = outs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL redirect row %0d: got %b want %b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mdu_latency();
    stim_t st[$];
    logic [9:0] ex[$];
    logic [9:0] got, e;
    st.push_back(mk(1, 1, 0, 0)); ex.push_back(MSTART);
    st.push_back(mk(1, 1, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(1, 0, 1, 0)); ex.push_back(MWAIT);
    st.push_back(mk_lu(5, 5, 1, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(MDONE);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(RUNV);
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = outs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mdu_lat row %0d: got %b want %b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mdu_backpressure();
    stim_t st[$];
    logic [9:0] ex[$];
    logic [9:0] got, e;
    st.push_back(mk(1, 1, 0, 0)); ex.push_back(MSTART);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(1, 0, 0, 1)); ex.push_back(MWAITB);
    st.push_back(mk(1, 0, 0, 1)); ex.push_back(MDONEB);
    st.push_back(mk(1, 0, 0, 1)); ex.push_back(MDONEB);
    st.push_back(mk(1, 1, 1, 1)); ex.push_back(MDONEB);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(MDONE);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(RUNV);
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = outs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mdu_bp row %0d: got %b want %b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mdu();
    stim_t st[$];
    logic [9:0] ex[$];
    logic [9:0] got, e;
    st.push_back(mk(1, 1, 0, 0)); ex.push_back(MSTART);
    st.push_back(mk(1, 1, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(0, 1, 0, 0)); ex.push_back(ZERO);
    st.push_back(mk(1, 1, 0, 0)); ex.push_back(MSTART);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(MDONE);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(RUNV);
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = outs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rst_mid row %0d: got %b want %b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    logic [9:0] ex[$];
    logic [9:0] got, e;
    st.push_back(mk(1, 1, 0, 0)); ex.push_back(MSTART);
    st.push_back(mk(1, 1, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(1, 1, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(1, 1, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(1, 1, 0, 0)); ex.push_back(MDONE);
    st.push_back(mk(1, 1, 0, 0)); ex.push_back(MSTART);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(MWAIT);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(MDONE);
    st.push_back(mk_lu(4, 4, 1, 0, 0)); ex.push_back(LU);
    st.push_back(mk_lu(6, 0, 0, 6, 1)); ex.push_back(LU);
    st.push_back(mk(1, 0, 0, 0)); ex.push_back(RUNV);
    foreach (st[i]) begin
      drive(st[i]); sb.push_back(ex[i]);
      @(negedge clk);
      got = outs(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL b2b row %0d: got %b want %b", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    drive(mk(0, 0, 0, 0));
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_redirect();
    test_mdu_latency();
    test_mdu_backpressure();
    test_reset_mid_mdu();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage RV64 core. Drives the enable and flush (bubble-insert) controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. Resolves load-use hazards, control redirects from EX, LSU back-pressure, and multi-cycle MUL/DIV occupancy of the EX stage. The controller is a small FSM plus a latency counter; all other decisions are combinational from current inputs and state.

## Interface
- MDU_LAT, 4: cycles the MUL/DIV unit needs after the start pulse; legal range 2..63.
- CNT_W, 6: width of the latency counter.

- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID
- id_rs1_ren, id_rs2_ren  in  1 each  source actually read
- ex_rd  in  5  destination of the instruction in EX
- ex_wen  in  1  EX instruction writes rd
- ex_load  in  1  EX instruction is a load
- ex_mdu  in  1  EX instruction is a multi-cycle MUL/DIV
- ex_redirect  in  1  EX resolved a taken branch, jump or trap; PC target valid
- mem_busy  in  1  LSU is not finished with the MEM-stage access
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  stage register loads
- ifid_flush, idex_flush, exmem_flush  out  1 each  stage register loads a NOP bubble
- mdu_start  out  1  one-cycle pulse; the MDU latches its operands
- mdu_done  out  1  MDU result is valid on the EX output
- mdu_busy  out  1  FSM not in RUN

## Operation
- Rule: any `*_flush`=1 forces the matching `*_en`=1. When `*_flush`=0, `*_en`=0 means the register holds its value.
- FSM states:
  - RUN: normal flow.
  - MDU: EX occupied; counter running.
  - HOLD: MDU result ready, but MEM is stalled.
- RUN priority (highest first):
  1. mem_busy: all en=0, all flush=0.
  2. ex_redirect: pc_en=1 (loads target), ifid_flush=1, idex_flush=1, exmem_en=1. Load-use and ex_mdu are ignored (wrong-path or illegal combination).
  3. ex_mdu: mdu_start=1, pc_en=ifid_en=idex_en=0, exmem_flush=1. Counter is loaded with MDU_LAT-1. Next state is MDU.
  4. Load-use hazard: ex_load & ex_wen & ex_rd!=0 & ((id_rs1_ren & id_rs1==ex_rd) | (id_rs2_ren & id_rs2==ex_rd)). Drives pc_en=ifid_en=0, idex_flush=1, exmem_en=1.
  5. Otherwise: all en=1, all flush=0.
- MDU state:
  - Counter decrements every cycle, including cycles with mem_busy=1.
  - While counter!=0: pc_en=ifid_en=idex_en=0. If mem_busy=0, exmem_flush=1; if mem_busy=1, exmem_en=0.
  - When counter==0: mdu_done=1.
    - If mem_busy=0: all en=1, no flush, next state RUN.
    - If mem_busy=1: all en=0, next state HOLD.
- HOLD state: mdu_done=1 and all en=0 while mem_busy=1. On the first cycle with mem_busy=0: all en=1, next state RUN.
- ex_redirect, ex_load and ex_mdu are ignored outside RUN, because EX is frozen.
- Reset: while rst=0, every output is 0. On the next edge the state becomes RUN and the counter clears. After reset release, a still-asserted ex_mdu is accepted as a new operation.

## Timing
- All outputs are combinational from state, counter and inputs. There are no registered outputs.
- State and counter update on posedge clk.
- MDU accepted at cycle T:
  - mdu_start=1 at T only.
  - mdu_done=1 at T+MDU_LAT.
  - idex_en=0 for cycles T..T+MDU_LAT-1, and idex_en=1 at T+MDU_LAT when mem_busy=0.
  - EX therefore occupies MDU_LAT+1 cycles.
- Load-use costs exactly one bubble cycle. The following cycle re-evaluates with the load now in MEM, so there is no hazard.
- Redirect costs two bubbles (IF/ID and ID/EX) and takes effect in the same cycle ex_redirect is seen with mem_busy=0.
- Counter never wraps. The MDU state exits at 0, and the counter is only reloaded from RUN.

## Test plan
- Load-use: ex_load=1, ex_wen=1, ex_rd=5, id_rs2=5, id_rs2_ren=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, then all en=1. Repeat with ex_rd=0 -> no stall.
- Redirect over hazard: the load-use condition above plus ex_redirect=1 -> pc_en=1, ifid_flush=1, idex_flush=1, and no load-use stall.
- MDU latency, MDU_LAT=4, ex_mdu at T:
  - mdu_start pulses at T.
  - exmem_flush=1 at T..T+3.
  - mdu_done=1 and all en=1 at T+4.
  - mdu_busy=1 at T+1..T+4.
  - Back in RUN at T+5.
- MDU with back-pressure: mem_busy=1 during T+3..T+6 -> counter still expires at T+4; state HOLD at T+5..T+6 with mdu_done=1 and all en=0; all en=1 at T+7, when mem_busy=0.
- mem_busy in RUN with ex_redirect=1 -> all en=0 and no flush until mem_busy falls; the redirect then executes that cycle.
- Reset mid-MDU: rst=0 at T+2 -> all outputs 0; after release, state is RUN, no mdu_done pulse, and a held ex_mdu produces a fresh mdu_start.
